chip_74161n_emu: RTL and testbench

//  Responder-side model of a 74161 4-bit synchronous binary counter, presented on the

---
 rtl/chip_74161n_emu.sv | 139 +++++++++++++
 tb/tb_chip_74161n_emu.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/chip_74161n_emu.sv
// chip_74161n_emu: responder-side emulation of a 74161 4-bit synchronous binary counter on
// the pin bus a chip checker drives and samples, so checker FSMs can be exercised without
// a physical IC in the socket.
//
// All pin inputs pass through SYNC_STAGES flops into the Clk domain. The checker's pin clock
// (Pin2) is rising-edge detected against the previous synced value. The detector is masked
// for SYNC_STAGES+1 Clk cycles after Reset releases, so a Pin2 already high is not counted.
//
// Ports:
//   Clk       system clock
//   Reset     asynchronous active-low reset
//   Pin1      CLR_n   (clear, active low)
//   Pin2      CLK     (pin clock from the checker)
//   Pin3..6   A..D    (parallel load data, bit 0..3)
//   Pin7      ENP     (count enable P)
//   Pin9      LOAD_n  (synchronous load, active low)
//   Pin10     ENT     (count enable T, also gates RCO)
//   Pin11..14 QD..QA  (count outputs, bit 3..0)
//   Pin15     RCO     (ripple carry out)
//   Fault_En  fault injection select, present only when CHIP_EMU_FAULT_EN is defined
//
// Optional feature macro: CHIP_EMU_FAULT_EN. When defined, Fault_En=1 inverts the output pin
// for Q[FAULT_BIT]; internal Q and RCO are unaffected.

module chip_74161n_emu #(
  parameter int unsigned SYNC_STAGES = 2,  // 2..4
  parameter int unsigned FAULT_BIT   = 0   // 0=QA .. 3=QD
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Pin1,
  input  logic Pin2,
  input  logic Pin3,
  input  logic Pin4,
  input  logic Pin5,
  input  logic Pin6,
  input  logic Pin7,
  input  logic Pin9,
  input  logic Pin10,
`ifdef CHIP_EMU_FAULT_EN
  input  logic Fault_En,
`endif
  output logic Pin11,
  output logic Pin12,
  output logic Pin13,
  output logic Pin14,
  output logic Pin15
);

  localparam int unsigned NumIn      = 9;
  localparam int unsigned WarmCycles = SYNC_STAGES + 1;

  // Bit positions of each pin in the synchronizer vector.
  localparam int unsigned IdxClr  = 0;
  localparam int unsigned IdxClk  = 1;
  localparam int unsigned IdxA    = 2;
  localparam int unsigned IdxEnp  = 6;
  localparam int unsigned IdxLoad = 7;
  localparam int unsigned IdxEnt  = 8;

  logic [NumIn-1:0] pins_raw;
  logic [NumIn-1:0] sync_q [SYNC_STAGES];
  logic [NumIn-1:0] synced;

  logic       prev_clk_q;
  logic [2:0] warm_q, warm_d;
  logic       warm_done;
  logic       rise;

  logic [3:0] q_q, q_d;
  logic       rco;
  logic       fault_active;
  logic [3:0] fault_mask;
  logic [3:0] q_pins;

  assign pins_raw = {Pin10, Pin9, Pin7, Pin6, Pin5, Pin4, Pin3, Pin2, Pin1};
  assign synced   = sync_q[SYNC_STAGES-1];

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= pins_raw;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  // Warm-up counter saturates at WarmCycles; the rise detector is live only once it does.
  assign warm_done = (warm_q == 3'(WarmCycles));
  assign warm_d    = warm_done ? warm_q : warm_q + 3'd1;
  assign rise      = warm_done & synced[IdxClk] & ~prev_clk_q;

  always_comb begin
    q_d = q_q;
    if (!synced[IdxClr]) begin
      // Clear dominates; a rise seen while clear is held is simply dropped.
      q_d = 4'h0;
    end else if (rise && !synced[IdxLoad]) begin
      q_d = synced[IdxA +: 4];
    end else if (rise && synced[IdxEnp] && synced[IdxEnt]) begin
      q_d = q_q + 4'h1;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      q_q        <= 4'h0;
      prev_clk_q <= 1'b0;
      warm_q     <= 3'd0;
    end else begin
      q_q        <= q_d;
      prev_clk_q <= synced[IdxClk];
      warm_q     <= warm_d;
    end
  end

  // RCO follows registered Q and synced ENT; it does not wait for a pin clock.
  assign rco = synced[IdxEnt] & (q_q == 4'hF);

`ifdef CHIP_EMU_FAULT_EN
  assign fault_active = Fault_En;
`else
  assign fault_active = 1'b0;
`endif

  assign fault_mask = fault_active ? (4'b0001 << FAULT_BIT) : 4'b0000;
  assign q_pins     = q_q ^ fault_mask;

  assign Pin11 = q_pins[3];
  assign Pin12 = q_pins[2];
  assign Pin13 = q_pins[1];
  assign Pin14 = q_pins[0];
  assign Pin15 = rco;

endmodule

// File: tb/tb_chip_74161n_emu.sv
module tb_chip_74161n_emu;

  logic Clk = 1'b0;
  logic Reset;
  logic Pin1, Pin2, Pin3, Pin4, Pin5, Pin6, Pin7, Pin9, Pin10;
  logic Pin11, Pin12, Pin13, Pin14, Pin15;
`ifdef CHIP_EMU_FAULT_EN
  logic Fault_En = 1'b0;
`endif

  int passed = 0;
  int total  = 0;

  chip_74161n_emu #(
    .SYNC_STAGES(2),
    .FAULT_BIT  (0)
  ) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .Pin1    (Pin1),
    .Pin2    (Pin2),
    .Pin3    (Pin3),
    .Pin4    (Pin4),
    .Pin5    (Pin5),
    .Pin6    (Pin6),
    .Pin7    (Pin7),
    .Pin9    (Pin9),
    .Pin10   (Pin10),
`ifdef CHIP_EMU_FAULT_EN
    .Fault_En(Fault_En),
`endif
    .Pin11   (Pin11),
    .Pin12   (Pin12),
    .Pin13   (Pin13),
    .Pin14   (Pin14),
    .Pin15   (Pin15)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic       clr_n;
    logic       load_n;
    logic       enp;
    logic       ent;
    logic [3:0] data;
    logic       pulse;
    logic [3:0] exp_q;
    logic       exp_rco;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [3:0] q_pins();
    return {Pin11, Pin12, Pin13, Pin14};
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic set_in(input logic clr_n, input logic load_n, input logic enp,
                        input logic ent, input logic [3:0] data);
    Pin1  = clr_n;
    Pin9  = load_n;
    Pin7  = enp;
    Pin10 = ent;
    {Pin6, Pin5, Pin4, Pin3} = data;
  endtask

  // Pin2 high and low for 4 Clk cycles each, comfortably above SYNC_STAGES+1.
  task automatic pulse();
    Pin2 = 1'b1;
    cyc(4);
    Pin2 = 1'b0;
    cyc(4);
  endtask

  function automatic vec_t mk(input logic clr_n, input logic load_n, input logic enp,
                              input logic ent, input logic [3:0] data, input logic pls,
                              input logic [3:0] exp_q, input logic exp_rco);
    vec_t v;
    v.clr_n = clr_n; v.load_n = load_n; v.enp = enp; v.ent = ent;
    v.data = data; v.pulse = pls; v.exp_q = exp_q; v.exp_rco = exp_rco;
    return v;
  endfunction

  initial begin
    // Count 1..15 then wrap to 0; RCO only at 15.
    for (int i = 1; i <= 16; i++) begin
      logic [3:0] e;
      e = 4'(i);
      vecs.push_back(mk(1, 1, 1, 1, 4'h0, 1, e, (e == 4'hF)));
    end
    vecs.push_back(mk(1, 0, 1, 1, 4'hA, 1, 4'hA, 0));  // load 1010
    vecs.push_back(mk(1, 1, 0, 1, 4'h0, 1, 4'hA, 0));  // ENP low: hold
    vecs.push_back(mk(1, 0, 1, 1, 4'h5, 0, 4'hA, 0));  // LOAD_n low, no rise: hold
    vecs.push_back(mk(1, 0, 1, 1, 4'hF, 1, 4'hF, 1));  // load F, RCO up
    vecs.push_back(mk(1, 1, 1, 0, 4'h0, 0, 4'hF, 0));  // ENT low: RCO down
    vecs.push_back(mk(1, 1, 1, 1, 4'h0, 0, 4'hF, 1));  // ENT back: RCO up
    vecs.push_back(mk(1, 1, 0, 1, 4'h0, 1, 4'hF, 1));  // ENT alone does not count
    vecs.push_back(mk(1, 1, 1, 0, 4'h0, 1, 4'hF, 0));  // ENP alone does not count
    vecs.push_back(mk(1, 1, 1, 1, 4'h0, 1, 4'h0, 0));  // wrap
    vecs.push_back(mk(1, 0, 1, 1, 4'h7, 1, 4'h7, 0));  // load 7

    // Reset with Pin2 already high: no count at release.
    set_in(1, 1, 1, 1, 4'h0);
    Pin2  = 1'b1;
    Reset = 1'b0;
    cyc(3);
    check("reset_q", {4'h0, q_pins()}, 8'h00);
    check("reset_rco", {7'h0, Pin15}, 8'h00);
    Reset = 1'b1;
    cyc(10);
    check("warmup_no_count", {4'h0, q_pins()}, 8'h00);
    Pin2 = 1'b0;
    cyc(4);

    foreach (vecs[i]) begin
      set_in(vecs[i].clr_n, vecs[i].load_n, vecs[i].enp, vecs[i].ent, vecs[i].data);
      cyc(4);
      if (vecs[i].pulse) pulse();
      else cyc(4);
      check($sformatf("vec%0d_q", i), {4'h0, q_pins()}, {4'h0, vecs[i].exp_q});
      check($sformatf("vec%0d_rco", i), {7'h0, Pin15}, {7'h0, vecs[i].exp_rco});
    end

    // Clear and rise in the same cycle: clear wins, no count/load.
    set_in(1, 1, 1, 1, 4'h0);
    cyc(4);
    Pin1 = 1'b0;
    Pin2 = 1'b1;
    cyc(4);
    check("clr_with_rise", {4'h0, q_pins()}, 8'h00);
    Pin2 = 1'b0;
    cyc(4);
    for (int i = 0; i < 3; i++) begin
      pulse();
      check($sformatf("clr_held_%0d", i), {4'h0, q_pins()}, 8'h00);
    end
    Pin1 = 1'b1;
    cyc(6);
    check("clr_release_no_deferred", {4'h0, q_pins()}, 8'h00);

    // RCO drops within SYNC_STAGES+1 cycles of ENT falling, Q untouched.
    set_in(1, 0, 1, 1, 4'hF);
    cyc(4);
    pulse();
    check("rco_high_at_f", {7'h0, Pin15}, 8'h01);
    Pin9  = 1'b1;
    Pin10 = 1'b0;
    cyc(3);
    check("rco_fast_drop", {7'h0, Pin15}, 8'h00);
    check("rco_drop_q_hold", {4'h0, q_pins()}, 8'h0F);

    // Reset mid-count clears at once; warm-up reruns, then counting resumes.
    set_in(1, 0, 1, 1, 4'h9);
    cyc(4);
    pulse();
    check("pre_reset_load", {4'h0, q_pins()}, 8'h09);
    Reset = 1'b0;
    #1;
    check("midcount_reset_q", {4'h0, q_pins()}, 8'h00);
    cyc(2);
    set_in(1, 1, 1, 1, 4'h0);
    Reset = 1'b1;
    cyc(8);
    pulse();
    check("post_reset_count", {4'h0, q_pins()}, 8'h01);

`ifdef CHIP_EMU_FAULT_EN
    set_in(1, 0, 1, 1, 4'h4);
    cyc(4);
    pulse();
    Fault_En = 1'b1;
    #1;
    check("fault_on_pins", {4'h0, q_pins()}, 8'h05);
    check("fault_on_rco", {7'h0, Pin15}, 8'h00);
    Fault_En = 1'b0;
    #1;
    check("fault_off_pins", {4'h0, q_pins()}, 8'h04);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
